// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, access ops,
// interrupt cause codes and the fixed misa value.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  localparam logic [4:0] IRQ_CODE_MSI        = 5'd3;
  localparam logic [4:0] IRQ_CODE_MTI        = 5'd7;
  localparam logic [4:0] IRQ_CODE_MEI        = 5'd11;
  localparam int         IRQ_CODE_LOCAL_BASE = 16;

  typedef enum logic [1:0] {
    CSR_OP_READ = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_t;

  // Value a CSR takes after applying the access op to its current contents.
  function automatic logic [31:0] csr_apply_op(csr_op_t op, logic [31:0] old_val,
                                               logic [31:0] wdata);
    case (op)
      CSR_OP_RW: return wdata;
      CSR_OP_RS: return old_val | wdata;
      CSR_OP_RC: return old_val & ~wdata;
      default:   return old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free counter with independently loadable halves. A load of either
// half takes precedence over the increment in that cycle; the untouched half
// holds, so a carry into the high word only comes from a real increment.
module csr_counter64
  import csr_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  // Load, increment or hold the counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= 64'd0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wdata;
      if (wr_hi) count[63:32] <= wdata;
    end else if (inc_en) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: register access, interrupt pending/cause tracking,
// trap entry/MRET state updates and the trap vector for the core.
module csr_file
  import csr_pkg::*;
#(
  parameter int          NUM_LOCAL_IRQ = 4,
  parameter bit          HAS_COUNTERS  = 1'b1,
  parameter logic [31:0] HART_ID       = 32'd0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     csr_en,
  input  logic [1:0]               csr_op,
  input  logic [11:0]              csr_addr,
  input  logic [31:0]              csr_wdata,
  output logic [31:0]              csr_rdata,
  output logic                     csr_illegal,
  input  logic                     irq_software,
  input  logic                     irq_timer,
  input  logic                     irq_external,
  input  logic [NUM_LOCAL_IRQ-1:0] irq_local,
  input  logic                     instr_retire,
  input  logic                     trap_take,
  input  logic [31:0]              trap_cause,
  input  logic [31:0]              trap_pc,
  input  logic [31:0]              trap_tval,
  input  logic                     mret,
  output logic                     irq_pending,
  output logic [31:0]              irq_cause,
  output logic [31:0]              trap_vector,
  output logic [31:0]              mepc_out,
  output logic                     mstatus_mie
);

  localparam logic [31:0] MIE_MASK =
    32'h0000_0888 | (((32'd1 << NUM_LOCAL_IRQ) - 32'd1) << IRQ_CODE_LOCAL_BASE);

  logic        mpie_q;
  logic [31:0] mie_q;
  logic [29:0] mtvec_base_q;
  logic        mtvec_mode_q;
  logic [31:0] mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle, minstret;
  logic [31:0] mip, mstatus_val, mepc_val, csr_new;
  logic        addr_known, addr_ro, csr_wr_en;
  logic        irq_any;
  logic [4:0]  irq_code;

  assign mepc_val    = mepc_q & 32'hFFFF_FFFC;
  assign mepc_out    = mepc_val;
  assign mstatus_val = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mstatus_mie, 3'd0};

  // Live view of the interrupt lines.
  always_comb begin
    mip = 32'd0;
    mip[3]  = irq_software;
    mip[7]  = irq_timer;
    mip[11] = irq_external;
    mip[IRQ_CODE_LOCAL_BASE +: NUM_LOCAL_IRQ] = irq_local;
  end

  // Read mux and address classification.
  always_comb begin
    csr_rdata  = 32'd0;
    addr_known = 1'b1;
    addr_ro    = 1'b0;
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = mstatus_val;
      CSR_MISA:      begin csr_rdata = MISA_VALUE; addr_ro = 1'b1; end
      CSR_MIE:       csr_rdata = mie_q;
      CSR_MTVEC:     csr_rdata = {mtvec_base_q, 1'b0, mtvec_mode_q};
      CSR_MSCRATCH:  csr_rdata = mscratch_q;
      CSR_MEPC:      csr_rdata = mepc_val;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_MTVAL:     csr_rdata = mtval_q;
      CSR_MIP:       begin csr_rdata = mip; addr_ro = 1'b1; end
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
      CSR_MHARTID:   begin csr_rdata = HART_ID; addr_ro = 1'b1; end
      default:       addr_known = 1'b0;
    endcase
  end

  assign csr_new     = csr_apply_op(csr_op_t'(csr_op), csr_rdata, csr_wdata);
  assign csr_illegal = csr_en && (!addr_known || (addr_ro && csr_op != CSR_OP_READ));
  // Trap and MRET commits win over a software write in the same cycle.
  assign csr_wr_en   = csr_en && (csr_op != CSR_OP_READ) && addr_known && !addr_ro &&
                       !trap_take && !mret;

  // Highest-priority enabled interrupt: MEI > MSI > MTI > lowest local index.
  always_comb begin
    logic [31:0] active;
    active   = mip & mie_q;
    irq_any  = |active;
    irq_code = 5'd0;
    for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
      if (active[IRQ_CODE_LOCAL_BASE + i]) irq_code = 5'(IRQ_CODE_LOCAL_BASE + i);
    end
    if (active[7])  irq_code = IRQ_CODE_MTI;
    if (active[3])  irq_code = IRQ_CODE_MSI;
    if (active[11]) irq_code = IRQ_CODE_MEI;
  end

  // Vectored mode only applies to interrupts; exceptions go to BASE.
  always_comb begin
    if (mtvec_mode_q && trap_cause[31])
      trap_vector = {mtvec_base_q, 2'b00} + {25'd0, trap_cause[4:0], 2'b00};
    else
      trap_vector = {mtvec_base_q, 2'b00};
  end

  // Architectural state: reset, then trap entry, then MRET, then CSR writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mpie_q       <= 1'b0;
      mie_q        <= 32'd0;
      mtvec_base_q <= 30'd0;
      mtvec_mode_q <= 1'b0;
      mscratch_q   <= 32'd0;
      mepc_q       <= 32'd0;
      mcause_q     <= 32'd0;
      mtval_q      <= 32'd0;
    end else if (trap_take) begin
      mepc_q      <= trap_pc;
      mcause_q    <= trap_cause;
      mtval_q     <= trap_tval;
      mpie_q      <= mstatus_mie;
      mstatus_mie <= 1'b0;
    end else if (mret) begin
      mstatus_mie <= mpie_q;
      mpie_q      <= 1'b1;
    end else if (csr_wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie <= csr_new[3];
          mpie_q      <= csr_new[7];
        end
        CSR_MIE:      mie_q <= csr_new & MIE_MASK;
        CSR_MTVEC: begin
          mtvec_base_q <= csr_new[31:2];
          // MODE values 2 and 3 are reserved; keep the current mode.
          if (!csr_new[1]) mtvec_mode_q <= csr_new[0];
        end
        CSR_MSCRATCH: mscratch_q <= csr_new;
        CSR_MEPC:     mepc_q     <= csr_new;
        CSR_MCAUSE:   mcause_q   <= csr_new;
        CSR_MTVAL:    mtval_q    <= csr_new;
        default: ;
      endcase
    end
  end

  // Registered interrupt request towards the core.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_pending <= 1'b0;
      irq_cause   <= 32'd0;
    end else begin
      irq_pending <= mstatus_mie && irq_any;
      irq_cause   <= irq_any ? {1'b1, 26'd0, irq_code} : 32'd0;
    end
  end

  generate
    if (HAS_COUNTERS) begin : g_counters
      csr_counter64 u_mcycle (
        .clock  (clock),
        .reset  (reset),
        .inc_en (1'b1),
        .wr_lo  (csr_wr_en && csr_addr == CSR_MCYCLE),
        .wr_hi  (csr_wr_en && csr_addr == CSR_MCYCLEH),
        .wdata  (csr_new),
        .count  (mcycle)
      );
      csr_counter64 u_minstret (
        .clock  (clock),
        .reset  (reset),
        .inc_en (instr_retire),
        .wr_lo  (csr_wr_en && csr_addr == CSR_MINSTRET),
        .wr_hi  (csr_wr_en && csr_addr == CSR_MINSTRETH),
        .wdata  (csr_new),
        .count  (minstret)
      );
    end else begin : g_no_counters
      assign mcycle   = 64'd0;
      assign minstret = 64'd0;
    end
  endgenerate

endmodule
